// File: rtl/sub16_seq.sv
// Sequential 16-bit subtractor: a16 - b16 - borrow_in, CHUNK bits per BUSY cycle with valid/ready handshakes.
// Optional macro SUB16_SEQ_OVF_EN adds the signed-overflow output ovf.
module sub16_seq #(
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic        borrow_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff16,
    output logic        borrow_out,
    output logic        zero
`ifdef SUB16_SEQ_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam int STEPS = 16 / CHUNK;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        borrow_q, borrow_d;
    logic [15:0] diff_q, diff_d;
    logic [CHUNK:0] chunk_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        // One extra top bit of the widened difference is the borrow out of this chunk.
        chunk_res = {1'b0, a_q[step_q*CHUNK +: CHUNK]}
                  - {1'b0, b_q[step_q*CHUNK +: CHUNK]}
                  - {{CHUNK{1'b0}}, borrow_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a16;
                    b_d      = b16;
                    borrow_d = borrow_in;
                    step_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[step_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                borrow_d = chunk_res[CHUNK];
                step_d   = step_q + 5'd1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff16     = diff_q;
    assign borrow_out = borrow_q;
    // Gated by DONE so the reset-cleared diff register does not read as a zero result.
    assign zero       = out_valid && (diff_q == 16'h0000);

`ifdef SUB16_SEQ_OVF_EN
    assign ovf = out_valid && (a_q[15] != b_q[15]) && (diff_q[15] != a_q[15]);
`endif

endmodule

// File: tb/tb_sub16_seq.sv
// Directed self-checking bench for sub16_seq at the default CHUNK of 4.
// Define SUB16_SEQ_OVF_EN for both files to also check the ovf output.
module tb_sub16_seq;

    localparam int LATENCY = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff16;
    logic        borrow_out;
    logic        zero;
`ifdef SUB16_SEQ_OVF_EN
    logic        ovf;
`endif

    int testsRun;
    int testsFailed;

    sub16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a16       (a16),
        .b16       (b16),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff16    (diff16),
        .borrow_out(borrow_out),
        .zero      (zero)
`ifdef SUB16_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand set, scrambles inputs while busy, checks latency and results, then handshakes.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 input logic [15:0] expDiff, input logic expBorrow, input logic expZero,
                                 input logic expOvf);
        int cycles;
        checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        a16       = a;
        b16       = b;
        borrow_in = bin;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 20) begin
            a16       = 16'($urandom);
            b16       = 16'($urandom);
            borrow_in = 1'($urandom);
            tick();
            cycles++;
        end
        checkOutput({tag, "/latency"}, 32'(cycles), 32'(LATENCY));
        checkOutput({tag, "/diff16"}, 32'(diff16), 32'(expDiff));
        checkOutput({tag, "/borrow_out"}, 32'(borrow_out), 32'(expBorrow));
        checkOutput({tag, "/zero"}, 32'(zero), 32'(expZero));
`ifdef SUB16_SEQ_OVF_EN
        checkOutput({tag, "/ovf"}, 32'(ovf), 32'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unexpected unknown ovf expectation");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "/out_valid_after"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "/in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        borrow;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int seen;
        testsRun    = 0;
        testsFailed = 0;
        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a16       = '0;
        b16       = '0;
        borrow_in = 1'b0;
        #12;
        checkOutput("reset/diff16", 32'(diff16), 32'd0);
        checkOutput("reset/borrow_out", 32'(borrow_out), 32'd0);
        checkOutput("reset/zero", 32'(zero), 32'd0);
        checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset/in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                          vecs[i].diff, vecs[i].borrow, vecs[i].zero, vecs[i].ovf);
        end

        // Result must hold while out_ready stays low and new operands are offered.
        a16       = 16'h0005;
        b16       = 16'h0003;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LATENCY) tick();
        checkOutput("hold/out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            a16       = 16'hF00D + 16'(c);
            b16       = 16'h0BAD - 16'(c);
            borrow_in = 1'(c);
            in_valid  = 1'b1;
            tick();
            checkOutput($sformatf("hold%0d/diff16", c), 32'(diff16), 32'h0002);
            checkOutput($sformatf("hold%0d/borrow_out", c), 32'(borrow_out), 32'd0);
            checkOutput($sformatf("hold%0d/zero", c), 32'(zero), 32'd0);
            checkOutput($sformatf("hold%0d/in_ready", c), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold%0d/out_valid", c), 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("hold/extra_results", 32'(seen), 32'd0);

        // Reset in the middle of BUSY discards the operation.
        a16       = 16'h5555;
        b16       = 16'h1111;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset/diff16", 32'(diff16), 32'd0);
        checkOutput("midreset/borrow_out", 32'(borrow_out), 32'd0);
        checkOutput("midreset/zero", 32'(zero), 32'd0);
        checkOutput("midreset/out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset/in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        seen  = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("midreset/stray_valid", 32'(seen), 32'd0);
        applyStimulus("postreset", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sub16_seq.md
SUB16_SEQ -- requirements
Module: sub16_seq

Interface
REQ-001 SHALL have parameter: CHUNK, default 4, bits subtracted per BUSY cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand set presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a16  input  16  minuend.
REQ-007 SHALL have port: b16  input  16  subtrahend.
REQ-008 SHALL have port: borrow_in  input  1  borrow into bit 0.
REQ-009 SHALL have port: out_valid  output  1  result held on outputs.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: diff16  output  16  a16 - b16 - borrow_in, modulo 2^16.
REQ-012 SHALL have port: borrow_out  output  1  borrow out of bit 15; 1 when unsigned a16 < b16 + borrow_in.
REQ-013 SHALL have port: zero  output  1  diff16 == 16'h0000.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid && in_ready, latch a16, b16 and borrow_in, clear step counter, go to BUSY; otherwise remain in IDLE.
REQ-016 BUSY: each cycle compute diff bits [k*CHUNK +: CHUNK] = a - b - borrow for step k, register chunk result and new borrow, increment k.
REQ-017 BUSY: after step k = 16/CHUNK - 1, go to DONE; out_valid rises exactly 16/CHUNK cycles after the accepting edge (4 cycles at default).
REQ-018 DONE: diff16, borrow_out and zero SHALL hold stable while out_ready = 0; on out_ready = 1, go to IDLE.
REQ-019 in_valid, a16, b16 and borrow_in SHALL be ignored outside IDLE; operands changing during BUSY SHALL NOT affect the result.
REQ-020 Minimum turnaround: DONE handshake edge, then one IDLE cycle, then next accept; throughput one result per 16/CHUNK + 2 cycles.
REQ-021 Results SHALL equal the 16-bit ripple-borrow result bit-exactly for all operand and borrow_in values.
REQ-022 zero SHALL be derived from the final registered diff16, not from partial chunks.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, step counter 0, borrow register 0, diff16 = 16'h0000, borrow_out = 0, zero = 0, out_valid = 0, in_ready = 1 after release.
REQ-024 Reset asserted in BUSY or DONE SHALL discard the operation in flight; no out_valid pulse after release.

Configuration
REQ-025 With macro SUB16_SEQ_OVF_EN defined, SHALL add output port ovf (1 bit) = signed overflow: (a[15] != b[15]) && (diff16[15] != a[15]), valid with out_valid, reset to 0.
REQ-026 Without SUB16_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 a16=0x0005, b16=0x0003, borrow_in=0 -> diff16=0x0002, borrow_out=0, zero=0, out_valid 4 cycles after accept.
REQ-028 a16=0x0000, b16=0x0001, borrow_in=0 -> diff16=0xFFFF, borrow_out=1; a16=0x0000, b16=0x0000, borrow_in=1 -> diff16=0xFFFF, borrow_out=1.
REQ-029 a16=0x1234, b16=0x1234, borrow_in=0 -> diff16=0x0000, zero=1, borrow_out=0.
REQ-030 With SUB16_SEQ_OVF_EN: a16=0x8000, b16=0x0001 -> diff16=0x7FFF, ovf=1; a16=0x7FFF, b16=0xFFFF -> diff16=0x8000, ovf=1.
REQ-031 out_ready held 0 for 5 cycles in DONE, while a16 and b16 change and in_valid=1 -> outputs stable, in_ready=0, no second accept; release gives exactly one result.
REQ-032 rst_n pulsed low during BUSY step 2 -> all outputs at reset values immediately, no out_valid afterward, next operation 0x0010-0x0001 -> diff16=0x000F.
